// File: rtl/wptr_full_if.sv
// Write-side FIFO pointer bundle between the writer, the read-pointer
// synchronizer and the write pointer / full-flag controller.
interface wptr_full_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  winc;
  logic [ADDR_WIDTH:0]   wq2_rptr;
  logic                  clr_ovf;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  overflow;

  modport master (
    output winc, wq2_rptr, clr_ovf,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, overflow
  );

  modport slave (
    input  winc, wq2_rptr, clr_ovf,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, overflow
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain half of an async FIFO: binary/Gray write pointer, full and
// almost-full flags, fill-level estimate and a sticky overflow flag.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH   = 6,
  parameter int AFULL_THRESH = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  wptr_full_if.slave   bus
);
  localparam int PW = ADDR_WIDTH + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic          wen_p0;
  logic [PW-1:0] wbin_p0;
  logic [PW-1:0] wgray_p0;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_p0;
  logic          full_p0;
  logic          afull_p0;
  logic          ovf_set_p0;

  logic [PW-1:0] wbin_p1;
  logic [PW-1:0] wptr_p1;
  logic          wfull_p1;
  logic          walmost_full_p1;
  logic [PW-1:0] wlevel_p1;
  logic          overflow_p1;

  // Stage p0: next-pointer, flag and level arithmetic from current state
  always_comb begin
    wen_p0     = bus.winc & ~wfull_p1 & rst_n;
    wbin_p0    = wbin_p1 + PW'(wen_p0);
    wgray_p0   = bin2gray(wbin_p0);
    rbin_s     = gray2bin(bus.wq2_rptr);
    level_p0   = wbin_p0 - rbin_s;
    // Full when the pointers differ only in the wrap bit: in Gray, top two bits inverted.
    full_p0    = (wgray_p0 == {~bus.wq2_rptr[PW-1:PW-2], bus.wq2_rptr[PW-3:0]});
    afull_p0   = (level_p0 >= PW'(AFULL_THRESH));
    ovf_set_p0 = bus.winc & wfull_p1;
  end

  // Stage p1: registered pointer and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_p1         <= '0;
      wptr_p1         <= '0;
      wfull_p1        <= 1'b0;
      walmost_full_p1 <= 1'b0;
      wlevel_p1       <= '0;
      overflow_p1     <= 1'b0;
    end else begin
      wbin_p1         <= wbin_p0;
      wptr_p1         <= wgray_p0;
      wfull_p1        <= full_p0;
      walmost_full_p1 <= afull_p0;
      wlevel_p1       <= level_p0;
      if (ovf_set_p0) begin
        overflow_p1 <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_p1 <= 1'b0;
      end
    end
  end

  assign bus.wen          = wen_p0;
  assign bus.waddr        = wbin_p1[ADDR_WIDTH-1:0];
  assign bus.wptr         = wptr_p1;
  assign bus.wfull        = wfull_p1;
  assign bus.walmost_full = walmost_full_p1;
  assign bus.wlevel       = wlevel_p1;
  assign bus.overflow     = overflow_p1;
endmodule
